// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction-fetch initiator.
// Owns the PC and issues word-aligned fetches to instruction memory, with at most one
// request outstanding. Returned words are buffered with their PC in a small FIFO and
// handed to decode over a valid/ready interface. A redirect flushes the buffer, loads
// a new PC and discards any response still in flight.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   imem_req_valid/ready/addr        fetch request channel (addr bits [1:0] always 0)
//   imem_rsp_valid/data              fetch response channel (no backpressure)
//   redirect_valid/redirect_pc       single-cycle redirect of the fetch stream
//   if_valid/if_ready/if_instr/if_pc decode-side handshake, driven from the FIFO head
//   fetch_cnt, stall_cnt             performance counters, present only when the
//                                    IFETCH_PERF_EN macro is defined
module ifetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam int unsigned    PtrW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned    CntW     = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);
  localparam logic [31:0]    Nop      = 32'h0000_0013;

  typedef enum logic [0:0] {SReq, SWait} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic            drop_q, drop_d;
  logic            req_valid_q, req_valid_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     last_pc_q, last_pc_d;
  logic [31:0]     fifo_pc_q    [FIFO_DEPTH];
  logic [31:0]     fifo_instr_q [FIFO_DEPTH];

  logic req_fire, push, pop;

  // Redirect takes priority: it suppresses both the push and the pop of its cycle.
  assign req_fire = req_valid_q & imem_req_ready;
  assign pop      = if_valid & if_ready & ~redirect_valid;
  assign push     = (state_q == SWait) & imem_rsp_valid & ~drop_q & ~redirect_valid;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drop_d    = drop_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    last_pc_d = last_pc_q;

    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PtrW'(1);
      last_pc_d = fifo_pc_q[rd_ptr_q];
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
      pc_d     = pc_q + 32'd4;
    end
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end

    case (state_q)
      SReq: begin
        if (req_fire) state_d = SWait;
      end
      SWait: begin
        // Any response ends the wait; a dropped one also clears the drop flag.
        if (imem_rsp_valid) begin
          state_d = SReq;
          drop_d  = 1'b0;
        end
      end
      default: state_d = SReq;
    endcase

    if (redirect_valid) begin
      pc_d     = redirect_pc & ~32'h3;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      // A request that is (or becomes) outstanding belongs to the old stream.
      if ((state_q == SWait && !imem_rsp_valid) || (state_q == SReq && req_fire)) begin
        drop_d = 1'b1;
      end
    end

    req_valid_d = (state_d == SReq) && (count_d < DepthCnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SReq;
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      req_valid_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      last_pc_q   <= RESET_PC;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      req_valid_q <= req_valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      last_pc_q   <= last_pc_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]    <= pc_q;
      fifo_instr_q[wr_ptr_q] <= imem_rsp_data;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign if_valid       = (count_q != '0);
  assign if_instr       = if_valid ? fifo_instr_q[rd_ptr_q] : Nop;
  assign if_pc          = if_valid ? fifo_pc_q[rd_ptr_q] : last_pc_q;

`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;
  logic        stall;

  assign stall = ((state_q == SWait) && !imem_rsp_valid) || (req_valid_q && !imem_req_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (push)  fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch initiator: owns the PC, issues word-aligned fetch requests to the instruction memory port and collects the returned instruction words.
- Buffers fetched {pc, instr} pairs in a small FIFO and presents them to decode over a valid/ready interface.
- Handles branch/jump redirects by flushing the buffer and discarding any in-flight response.
- Sits between the instruction memory (responder) and the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000: PC fetched first after reset; bits [1:0] must be 0.
- FIFO_DEPTH, 2: entries in the fetch buffer; power of 2, minimum 2.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request this cycle
- imem_req_addr  output  32  byte address of fetch, bits [1:0] always 0
- imem_rsp_valid  input  1  response word valid (no backpressure)
- imem_rsp_data  input  32  fetched instruction word
- redirect_valid  input  1  one-cycle pulse: change fetch stream
- redirect_pc  input  32  new PC; bits [1:0] ignored and forced to 0
- if_valid  output  1  decode-side entry valid (FIFO not empty)
- if_ready  input  1  decode consumes entry
- if_instr  output  32  instruction at FIFO head; 32'h0000_0013 (NOP) when empty
- if_pc  output  32  PC of FIFO head; last-popped PC held when empty

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc=RESET_PC, FIFO empty, state=S_REQ, drop flag=0.
  - Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, if_valid=0, if_instr=32'h13, if_pc=RESET_PC.
- Outstanding requests: at most one at any time.
- FSM, two states:
  - S_REQ: imem_req_valid=1 iff (FIFO count < FIFO_DEPTH), with imem_req_addr=pc. On valid&&ready -> S_WAIT. While valid && !ready, addr holds stable except on redirect.
  - S_WAIT: imem_req_valid=0. On imem_rsp_valid:
    - If drop=0: push {pc, imem_rsp_data}, pc<=pc+4.
    - If drop=1: discard the word and clear drop.
    - In both cases -> S_REQ.
- Response latency: imem_rsp_valid is not sampled in S_REQ; the earliest accepted response is the cycle after request acceptance. Any latency >=1 is supported.
- Fetch throughput: one instruction per two cycles with zero-wait memory.
- PC arithmetic: 32-bit and modular; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
- Decode handshake:
  - Pop on if_valid && if_ready.
  - if_instr/if_pc are taken combinationally from the FIFO head.
  - Push and pop in the same cycle is allowed and leaves count unchanged.
  - When the FIFO is full, fetch stalls in S_REQ with imem_req_valid=0.
- Redirect (has priority over push and pop in the same cycle):
  - FIFO flushed; if_valid=0 in the next cycle.
  - pc<=redirect_pc & ~3.
  - In S_REQ: a pending un-accepted request is withdrawn; the next cycle requests the new pc. If the request is accepted in the redirect cycle itself, go to S_WAIT with drop=1.
  - In S_WAIT with no response this cycle: drop=1, stay in S_WAIT.
  - In S_WAIT with a response this cycle: discard the word, -> S_REQ at the new pc.
  - Back-to-back redirects: the last one wins; drop stays 1 until one response is absorbed.
- Reset asserted mid-transaction: all state cleared immediately; the memory side must also be reset (no stale response tolerated).

Optional Feature:
- Macro: IFETCH_PERF_EN.
- Defined: adds outputs fetch_cnt[31:0] and stall_cnt[31:0], both reset to 0 and wrapping modulo 2^32.
  - fetch_cnt increments on every non-dropped FIFO push.
  - stall_cnt increments on every cycle in S_WAIT without imem_rsp_valid, plus every cycle in S_REQ with imem_req_valid && !imem_req_ready.
- Undefined: ports and counters absent; core behaviour is identical.

Test Plan:
- Reset with RESET_PC=0, memory holding 0x13, 0x00100093, 0x00200113, always-ready, 1-cycle rsp, if_ready=1 -> first request addr 0x0; decode receives (0x0, 0x13), (0x4, 0x00100093), (0x8, 0x00200113) in order.
- if_ready=0 for 10 cycles, zero-wait memory -> exactly FIFO_DEPTH=2 entries buffered, imem_req_valid=0 afterwards; when if_ready=1 is raised, fetch resumes at 0x8.
- Redirect to 0x23 while in S_WAIT for addr 0x4 (rsp 3 cycles later) -> response for 0x4 dropped; next request addr 0x20; first decode entry has pc 0x20.
- Redirect in the same cycle as a push and a pop -> FIFO empty the next cycle, no entry with a stale pc ever reaches decode.
- imem_req_ready low 4 cycles with request at 0xC -> imem_req_addr holds 0xC, one acceptance only; under IFETCH_PERF_EN stall_cnt = 4.
- Redirect to 0xFFFF_FFFC -> fetches 0xFFFF_FFFC, then 0x0000_0000 (wrap).
